matrix_scan_reader: RTL and testbench

MATRIX_SCAN_READER -- requirements
Module: matrix_scan_reader

---
 rtl/matrix_scan_reader.sv | 160 ++++++++++++++++
 tb/tb_matrix_scan_reader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_reader.sv
// Walks a WIDTH x WIDTH grid through a single-read memory port and streams each
// cell (coordinates + 2-bit contents) downstream, counting 2'b10 cells and flagging timeouts.
module matrix_scan_reader #(
  parameter int WIDTH   = 6,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [2:0] mem_x,
  output logic [2:0] mem_y,
  output logic       mem_rd_valid,
  output logic       mem_wr_en,
  input  logic [1:0] mem_data,
  input  logic       mem_data_valid,
  output logic [2:0] cell_x,
  output logic [2:0] cell_y,
  output logic [1:0] cell_data,
  output logic       cell_valid,
  input  logic       cell_ready,
  output logic [6:0] hit_count,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, PUSH, FIN} state_e;

  localparam logic [2:0] LAST      = 3'(WIDTH - 1);
  localparam logic [6:0] HIT_MAX   = 7'(WIDTH * WIDTH);
  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);
  localparam logic [1:0] HIT_CODE  = 2'b10;

  function automatic logic [6:0] sat_inc(input logic [6:0] v);
    return (v >= HIT_MAX) ? HIT_MAX : v + 7'd1;
  endfunction

  state_e     state_q, state_d;
  logic [2:0] x_q, x_d, y_q, y_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic [2:0] mx_q, mx_d, my_q, my_d;
  logic [2:0] cx_q, cx_d, cy_q, cy_d;
  logic [1:0] cdata_q, cdata_d;
  logic [6:0] hit_q, hit_d;
  logic       err_q, err_d;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    wcnt_d  = wcnt_q;
    mx_d    = mx_q;
    my_d    = my_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    cdata_d = cdata_q;
    hit_d   = hit_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = 3'd0;
          y_d     = 3'd0;
          hit_d   = 7'd0;
          err_d   = 1'b0;
          wcnt_d  = 4'd0;
          state_d = REQ;
        end
      end
      REQ: begin
        wcnt_d  = 4'd0;
        state_d = WAIT;
      end
      WAIT: begin
        // Data arriving on the timeout cycle still counts as a good read.
        if (mem_data_valid) begin
          cdata_d = mem_data;
          if (mem_data == HIT_CODE) hit_d = sat_inc(hit_q);
          cx_d    = x_q;
          cy_d    = y_q;
          state_d = PUSH;
        end else if (wcnt_q >= WAIT_LAST) begin
          cdata_d = 2'b00;
          err_d   = 1'b1;
          cx_d    = x_q;
          cy_d    = y_q;
          state_d = PUSH;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      PUSH: begin
        if (cell_ready) begin
          if (x_q == LAST) begin
            x_d = 3'd0;
            if (y_q == LAST) begin
              y_d     = 3'd0;
              state_d = FIN;
            end else begin
              y_d     = y_q + 3'd1;
              state_d = REQ;
            end
          end else begin
            x_d     = x_q + 3'd1;
            state_d = REQ;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Memory coordinates only move when a new read is issued, so they hold between reads.
    if (state_d == REQ) begin
      mx_d = x_d;
      my_d = y_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= 3'd0;
      y_q     <= 3'd0;
      wcnt_q  <= 4'd0;
      mx_q    <= 3'd0;
      my_q    <= 3'd0;
      cx_q    <= 3'd0;
      cy_q    <= 3'd0;
      cdata_q <= 2'b00;
      hit_q   <= 7'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      wcnt_q  <= wcnt_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      cdata_q <= cdata_d;
      hit_q   <= hit_d;
      err_q   <= err_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == FIN);
  assign mem_rd_valid = (state_q == REQ) || (state_q == WAIT);
  assign mem_wr_en    = 1'b0;
  assign mem_x        = mx_q;
  assign mem_y        = my_q;
  assign cell_valid   = (state_q == PUSH);
  assign cell_x       = cx_q;
  assign cell_y       = cy_q;
  assign cell_data    = cdata_q;
  assign hit_count    = hit_q;
  assign err          = err_q;

endmodule

// File: tb/tb_matrix_scan_reader.sv
// Directed bench for matrix_scan_reader: a table-driven memory model answers reads,
// and a scoreboard queue holds the cells each scan is expected to stream.
module tb_matrix_scan_reader;
  localparam int W  = 6;
  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst, start, busy, done;
  logic [2:0] mem_x, mem_y, cell_x, cell_y;
  logic       mem_rd_valid, mem_wr_en, mem_data_valid, cell_valid, cell_ready, err;
  logic [1:0] mem_data, cell_data;
  logic [6:0] hit_count;

  matrix_scan_reader #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_x(mem_x), .mem_y(mem_y), .mem_rd_valid(mem_rd_valid), .mem_wr_en(mem_wr_en),
    .mem_data(mem_data), .mem_data_valid(mem_data_valid),
    .cell_x(cell_x), .cell_y(cell_y), .cell_data(cell_data),
    .cell_valid(cell_valid), .cell_ready(cell_ready),
    .hit_count(hit_count), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  int rd_age   = 0;
  int t0, t1, lat, nd0, exp_hits, n;
  logic exp_err;
  logic stray = 1'b0;
  logic [1:0] mem [8][8];
  int         resp_age [8][8];
  logic [7:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Memory model: answers when the read has been pending resp_age cycles (0 = never).
  initial begin
    mem_data = 2'b00;
    mem_data_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_rd_valid === 1'b1) rd_age++; else rd_age = 0;
      mem_data_valid = 1'b0;
      mem_data = 2'b00;
      if (mem_rd_valid === 1'b1) begin
        if (resp_age[mem_x][mem_y] == rd_age) begin
          mem_data_valid = 1'b1;
          mem_data = mem[mem_x][mem_y];
        end
      end else if (stray) begin
        mem_data_valid = 1'b1;
        mem_data = 2'b10;
      end
    end
  end

  // Scoreboard: every accepted cell is popped and compared.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
      if (cell_valid === 1'b1 && cell_ready === 1'b1) begin
        chk("sb_nonempty", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sb_cell_xyd", 32'({cell_x, cell_y, cell_data}), 32'(e));
        end
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        mem[i][j] = 2'b00;
        resp_age[i][j] = 2;
      end
  endtask

  task automatic load_expect();
    logic [1:0] d;
    exp_hits = 0;
    exp_err  = 1'b0;
    for (int y = 0; y < W; y++)
      for (int x = 0; x < W; x++) begin
        if (resp_age[x][y] == 0 || resp_age[x][y] > TO + 1) begin
          d = 2'b00;
          exp_err = 1'b1;
        end else begin
          d = mem[x][y];
          if (d == 2'b10) exp_hits++;
        end
        exp_q.push_back({3'(x), 3'(y), d});
      end
  endtask

  task automatic start_scan();
    nd0 = n_done;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    while (done !== 1'b1 && cyc - t0 < 3000) begin
      @(posedge clk); #1;
    end
    chk({tag, "_done_seen"}, 32'(done), 1);
    lat = cyc - t0;
  endtask

  task automatic wait_req(input int x, input int y);
    n = 0;
    while (!(mem_rd_valid === 1'b1 && mem_x == 3'(x) && mem_y == 3'(y)) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_req_seen", 32'(n < 1000), 1);
  endtask

  task automatic wait_cell(input string tag);
    n = 0;
    while (cell_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_cell_seen"}, 32'(n < 100), 1);
  endtask

  task automatic end_checks(input string tag);
    @(posedge clk); #1;
    chk({tag, "_done_low"}, 32'(done), 0);
    chk({tag, "_busy_low"}, 32'(busy), 0);
    chk({tag, "_one_done"}, 32'(n_done), 32'(nd0 + 1));
    chk({tag, "_hits"}, 32'(hit_count), 32'(exp_hits));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_all_cells"}, 32'(exp_q.size()), 0);
    chk({tag, "_wr_en"}, 32'(mem_wr_en), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cell_ready = 1'b1;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_valid", 32'(mem_rd_valid), 0);
    chk("rst_wr_en", 32'(mem_wr_en), 0);
    chk("rst_cell_valid", 32'(cell_valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_hits", 32'(hit_count), 0);
    chk("rst_coords", 32'({mem_x, mem_y, cell_x, cell_y, cell_data}), 0);
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("idle_no_start", 32'(busy), 0);

    // Full scan with two hits and one 01 cell.
    clear_mem();
    mem[2][2] = 2'b10; mem[5][0] = 2'b10; mem[1][1] = 2'b01;
    load_expect();
    start_scan();
    chk("t1_busy", 32'(busy), 1);
    chk("t1_first_req", 32'({mem_rd_valid, mem_x, mem_y}), 32'b1_000_000);
    wait_done("t1");
    chk("t1_latency", 32'(lat), 109);
    chk("t1_hits_fin", 32'(hit_count), 2);
    chk("t1_err_fin", 32'(err), 0);
    end_checks("t1");

    // Backpressure at (3,0), with stray valids outside WAIT.
    clear_mem();
    mem[3][0] = 2'b11; mem[4][4] = 2'b10;
    stray = 1'b1;
    load_expect();
    start_scan();
    wait_req(3, 0);
    cell_ready = 1'b0;
    wait_cell("t2");
    for (int k = 0; k < 5; k++) begin
      chk("t2_valid_held", 32'(cell_valid), 1);
      chk("t2_cell_stable", 32'({cell_x, cell_y, cell_data}), 32'({3'd3, 3'd0, 2'b11}));
      chk("t2_no_new_read", 32'(mem_rd_valid), 0);
      chk("t2_mem_x_held", 32'(mem_x), 3);
      @(posedge clk); #1;
    end
    cell_ready = 1'b1;
    wait_done("t2");
    stray = 1'b0;
    end_checks("t2");

    // Memory never answers at (0,1).
    clear_mem();
    resp_age[0][1] = 0; mem[0][1] = 2'b10; mem[4][4] = 2'b10;
    load_expect();
    start_scan();
    wait_req(0, 1);
    t1 = cyc;
    chk("t3_err_before", 32'(err), 0);
    wait_cell("t3");
    chk("t3_timeout_cycles", 32'(cyc - t1), 16);
    chk("t3_err_set", 32'(err), 1);
    chk("t3_data_zero", 32'({cell_x, cell_y, cell_data}), 32'({3'd0, 3'd1, 2'b00}));
    wait_done("t3");
    chk("t3_err_at_fin", 32'(err), 1);
    end_checks("t3");

    // Start pulse while busy at cell 10 = (4,1).
    clear_mem();
    mem[0][0] = 2'b10; mem[2][1] = 2'b10; mem[5][5] = 2'b10;
    load_expect();
    start_scan();
    wait_req(4, 1);
    chk("t4_hits_before", 32'(hit_count), 2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t4_hits_kept", 32'(hit_count), 2);
    chk("t4_still_cell10", 32'({busy, mem_rd_valid, mem_x, mem_y}), 32'({1'b1, 1'b1, 3'd4, 3'd1}));
    wait_done("t4");
    chk("t4_latency", 32'(lat), 109);
    end_checks("t4");

    // Reset during WAIT at (4,3), then a fresh scan.
    clear_mem();
    mem[1][0] = 2'b10;
    load_expect();
    start_scan();
    wait_req(4, 3);
    @(posedge clk); #1;
    chk("t5_in_wait", 32'({busy, mem_rd_valid, hit_count}), 32'({1'b1, 1'b1, 7'd1}));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_rd_valid", 32'(mem_rd_valid), 0);
    chk("t5_rst_cell_valid", 32'(cell_valid), 0);
    chk("t5_rst_hits", 32'(hit_count), 0);
    chk("t5_rst_misc", 32'({done, err, mem_x, mem_y}), 0);
    rst = 1'b0;
    exp_q.delete();
    repeat (4) begin @(posedge clk); #1; end
    chk("t5_idle_after_rst", 32'({busy, mem_rd_valid}), 0);
    clear_mem();
    mem[0][0] = 2'b01; mem[3][2] = 2'b10;
    load_expect();
    start_scan();
    chk("t5_restart_origin", 32'({mem_rd_valid, mem_x, mem_y}), 32'b1_000_000);
    wait_done("t5");
    chk("t5_latency", 32'(lat), 109);
    end_checks("t5");

    // Valid data arrives on the timeout cycle at (2,3).
    clear_mem();
    mem[2][3] = 2'b10;
    resp_age[2][3] = TO + 1;
    load_expect();
    start_scan();
    wait_done("t6");
    chk("t6_latency", 32'(lat), 109 + TO - 1);
    chk("t6_hits", 32'(hit_count), 1);
    chk("t6_err", 32'(err), 0);
    end_checks("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
